// File: rtl/equality_detector.sv
// equality_detector: 19-bit DR/AC equality detector for the accumulator datapath.
// EQ is purely combinational. EQ_R/NE_R/GT_R/LT_R hold a signed (two's complement)
// comparison that is captured on a rising clk edge while CMP_EN is high.
module equality_detector (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [18:0] DR,
    input  logic [18:0] AC,
    input  logic        CMP_EN,
    output logic        EQ,
    output logic        EQ_R,
    output logic        NE_R,
    output logic        GT_R,
    output logic        LT_R
);

    logic eq_c;
    logic gt_c;
    logic lt_c;

    logic eq_q, ne_q, gt_q, lt_q;
    logic eq_d, ne_d, gt_d, lt_d;

    // Signed compare: if the sign bits differ, the non-negative operand is greater;
    // otherwise the magnitude bits decide as an unsigned compare.
    always_comb begin
        eq_c = ~|(DR ^ AC);
        gt_c = 1'b0;
        if (DR[18] != AC[18]) begin
            gt_c = ~DR[18];
        end else begin
            gt_c = (DR[17:0] > AC[17:0]);
        end
        lt_c = ~eq_c & ~gt_c;
    end

    // Next-state: take the fresh comparison when enabled, otherwise hold.
    always_comb begin
        eq_d = eq_q;
        ne_d = ne_q;
        gt_d = gt_q;
        lt_d = lt_q;
        if (CMP_EN) begin
            eq_d = eq_c;
            ne_d = ~eq_c;
            gt_d = gt_c;
            lt_d = lt_c;
        end
    end

    // Status flag registers; asynchronous clear to the all-zero idle state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_q <= 1'b0;
            ne_q <= 1'b0;
            gt_q <= 1'b0;
            lt_q <= 1'b0;
        end else begin
            eq_q <= eq_d;
            ne_q <= ne_d;
            gt_q <= gt_d;
            lt_q <= lt_d;
        end
    end

    assign EQ   = eq_c;
    assign EQ_R = eq_q;
    assign NE_R = ne_q;
    assign GT_R = gt_q;
    assign LT_R = lt_q;

endmodule

// File: tb/tb_equality_detector.sv
// tb_equality_detector: directed and random checks of equality_detector.
// Flags are compared as the vector {EQ_R, NE_R, GT_R, LT_R}.
module tb_equality_detector;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic [18:0] dr;
    logic [18:0] ac;
    logic        cmp_en;
    logic        eq;
    logic        eq_r, ne_r, gt_r, lt_r;

    int n_assert;
    int n_fail;

    equality_detector dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .DR     (dr),
        .AC     (ac),
        .CMP_EN (cmp_en),
        .EQ     (eq),
        .EQ_R   (eq_r),
        .NE_R   (ne_r),
        .GT_R   (gt_r),
        .LT_R   (lt_r)
    );

    // Clock toggles only while clk_en is set, so the sweep can run clockless.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    function automatic logic [3:0] flags();
        return {eq_r, ne_r, gt_r, lt_r};
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic capture(input logic [18:0] d, input logic [18:0] a);
        @(negedge clk);
        dr     = d;
        ac     = a;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;
        cmp_en = 1'b0;
    endtask

    initial begin
        logic [18:0] rd;
        logic [18:0] ra;
        logic        req;
        logic        rgt;
        n_assert = 0;
        n_fail   = 0;
        clk_en   = 1'b0;
        rst_n    = 1'b0;
        cmp_en   = 1'b0;
        dr       = '0;
        ac       = '0;
        #1;
        chk("reset_flags", flags(), 4'b0000);

        // Combinational sweep, clock stopped
        dr = 19'd0;  ac = 19'd0;  #10; chk("eq_0_0",     {3'b0, eq}, 4'd1);
        dr = 19'd20; ac = 19'd40; #10; chk("eq_20_40",   {3'b0, eq}, 4'd0);
        dr = 19'd20; ac = 19'd20; #10; chk("eq_20_20",   {3'b0, eq}, 4'd1);
        dr = 19'd0;  ac = 19'd0;  #10; chk("eq_0_0b",    {3'b0, eq}, 4'd1);
        dr = 19'd0;  ac = 19'd1;  #10; chk("eq_0_1",     {3'b0, eq}, 4'd0);
        dr = 19'd2;  ac = 19'd3;  #10; chk("eq_2_3",     {3'b0, eq}, 4'd0);
        dr = 19'd29; ac = 19'h7FFE3; #10; chk("eq_29_m29", {3'b0, eq}, 4'd0);
        dr = 19'h7FFEC; ac = 19'h7FFEC; #10; chk("eq_m20_m20", {3'b0, eq}, 4'd1);
        dr = 19'd0;  ac = 19'd0;  #10; chk("eq_0_0c",    {3'b0, eq}, 4'd1);

        // Start clock, release reset between edges; first edge after release captures
        clk_en = 1'b1;
        @(negedge clk);
        chk("reset_hold_clk", flags(), 4'b0000);
        rst_n = 1'b1;
        dr = 19'd29; ac = 19'h7FFE3; cmp_en = 1'b1;
        @(posedge clk); #1; cmp_en = 1'b0;
        chk("cap_29_m29", flags(), 4'b0110);

        capture(19'h7FFEC, 19'd5);        chk("cap_m20_5",    flags(), 4'b0101);
        capture(19'h7FFEC, 19'h7FFEC);    chk("cap_m20_m20",  flags(), 4'b1000);
        capture(19'h3FFFF, 19'h40000);    chk("cap_max_min",  flags(), 4'b0110);
        capture(19'h7FFFF, 19'd0);        chk("cap_m1_0",     flags(), 4'b0101);
        capture(19'h7FFFF, 19'h7FFFF);    chk("cap_m1_m1",    flags(), 4'b1000);
        chk("eq_m1_m1", {3'b0, eq}, 4'd1);

        // Hold: CMP_EN low, DR changes only affect EQ
        capture(19'd7, 19'd7);            chk("hold_cap", flags(), 4'b1000);
        dr = 19'd8; #1;
        chk("hold_eq_drop", {3'b0, eq}, 4'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_flags", flags(), 4'b1000);
        end

        // Asynchronous reset between edges
        capture(19'd100, 19'd3);          chk("pre_rst_gt", flags(), 4'b0110);
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        chk("async_clear", flags(), 4'b0000);
        cmp_en = 1'b1;
        @(posedge clk); #1;
        chk("rst_beats_en", flags(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cmp_en = 1'b0;
        chk("first_after_rst", flags(), 4'b0110);

        // Random pairs against a signed reference
        for (int i = 0; i < 1000; i++) begin
            rd = 19'($urandom);
            ra = 19'($urandom);
            if ($urandom_range(3) == 0) ra = rd;
            req = (rd == ra);
            rgt = ($signed(rd) > $signed(ra));
            capture(rd, ra);
            chk("rand_eq", {3'b0, eq}, {3'b0, req});
            chk("rand_flags", flags(), {req, ~req, rgt, ~req & ~rgt});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
